// File: rtl/imdct_pkg.sv
// imdct_pkg: shared constants and FSM state type for the IMDCT pre-twiddle stage.
// Twiddle ROM layout: short block region first, long block region after it.
package imdct_pkg;

  localparam int SHORT_BASE = 0;
  localparam int SHORT_LEN  = 64;
  localparam int LONG_BASE  = 64;
  localparam int LONG_LEN   = 512;
  localparam int ROM_DEPTH  = 576;
  localparam int ROM_AW     = 10;
  localparam int IDX_W      = 9;
  localparam int FRAC       = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pretw_state_t;

endpackage

// File: rtl/imdct_cmul_round.sv
// imdct_cmul_round: two-stage complex multiply by (c, s) with half-up rounding.
// Build option IMDCT_PRETW_SAT_EN saturates the result; otherwise it wraps to DW bits.
module imdct_cmul_round #(
  parameter int DW   = 32,
  parameter int TW   = 32,
  parameter int FRAC = imdct_pkg::FRAC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_adv,
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  input  logic signed [TW-1:0] i_c,
  input  logic signed [TW-1:0] i_s,
  output logic signed [DW-1:0] o_re,
  output logic signed [DW-1:0] o_im
);
  import imdct_pkg::*;

  localparam int PW = DW + TW;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND = SW'(1) <<< (FRAC - 1);
`ifdef IMDCT_PRETW_SAT_EN
  localparam logic signed [SW-1:0] MAXV = SW'({1'b0, {(DW-1){1'b1}}});
  localparam logic signed [SW-1:0] MINV = ~MAXV;
`endif

  logic signed [PW-1:0] w_re_x;
  logic signed [PW-1:0] w_im_x;
  logic signed [PW-1:0] w_c_x;
  logic signed [PW-1:0] w_s_x;
  logic signed [PW-1:0] r_p0;
  logic signed [PW-1:0] r_p1;
  logic signed [PW-1:0] r_p2;
  logic signed [PW-1:0] r_p3;
  logic signed [SW-1:0] w_yr;
  logic signed [SW-1:0] w_yi;

  function automatic logic signed [DW-1:0] round_reduce(input logic signed [SW-1:0] y);
    logic signed [SW-1:0] sh;
    sh = (y + RND) >>> FRAC;
`ifdef IMDCT_PRETW_SAT_EN
    if (sh > MAXV)
      return MAXV[DW-1:0];
    else if (sh < MINV)
      return MINV[DW-1:0];
    else
      return sh[DW-1:0];
`else
    return sh[DW-1:0];
`endif
  endfunction

  assign w_re_x = PW'(i_re);
  assign w_im_x = PW'(i_im);
  assign w_c_x  = PW'(i_c);
  assign w_s_x  = PW'(i_s);

  // Stage 1: four full-width products, exact in PW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0 <= '0;
      r_p1 <= '0;
      r_p2 <= '0;
      r_p3 <= '0;
    end else if (i_adv) begin
      r_p0 <= w_re_x * w_c_x;
      r_p1 <= w_im_x * w_s_x;
      r_p2 <= w_re_x * w_s_x;
      r_p3 <= w_im_x * w_c_x;
    end
  end

  assign w_yr = SW'(r_p0) - SW'(r_p1);
  assign w_yi = SW'(r_p2) + SW'(r_p3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_re <= '0;
      o_im <= '0;
    end else if (i_adv) begin
      o_re <= round_reduce(w_yr);
      o_im <= round_reduce(w_yi);
    end
  end

endmodule

// File: rtl/imdct_pretwiddle.sv
// imdct_pretwiddle: walks the twiddle ROM for one short/long transform and streams twiddled samples.
// Build option IMDCT_PRETW_SAT_EN selects saturating output instead of wrap.
module imdct_pretwiddle #(
  parameter int DW         = 32,
  parameter int TW         = 32,
  parameter int FRAC       = imdct_pkg::FRAC,
  parameter int SHORT_BASE = imdct_pkg::SHORT_BASE,
  parameter int SHORT_LEN  = imdct_pkg::SHORT_LEN,
  parameter int LONG_BASE  = imdct_pkg::LONG_BASE,
  parameter int LONG_LEN   = imdct_pkg::LONG_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         blk_long,
  output logic                         busy,
  output logic                         done,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DW-1:0]         in_re,
  input  logic signed [DW-1:0]         in_im,
  output logic                         rom_en,
  output logic [imdct_pkg::ROM_AW-1:0] rom_addr,
  input  logic [2*TW-1:0]              rom_dout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DW-1:0]         out_re,
  output logic signed [DW-1:0]         out_im,
  output logic [imdct_pkg::IDX_W-1:0]  out_idx
);
  import imdct_pkg::*;

  localparam int AW = ROM_AW;

  pretw_state_t         r_state;
  logic [AW-1:0]        r_base;
  logic [AW-1:0]        r_len;
  logic [AW-1:0]        r_in_cnt;
  logic [AW-1:0]        r_out_cnt;
  logic                 r_busy;
  logic                 r_done;

  logic                 r_s1_vld;
  logic                 r_s2_vld;
  logic                 r_s3_vld;
  logic [IDX_W-1:0]     r_s1_idx;
  logic [IDX_W-1:0]     r_s2_idx;
  logic [IDX_W-1:0]     r_s3_idx;
  logic signed [DW-1:0] r_s1_re;
  logic signed [DW-1:0] r_s1_im;

  logic                 w_adv;
  logic                 w_in_hs;
  logic                 w_out_hs;
  logic signed [TW-1:0] w_c;
  logic signed [TW-1:0] w_s;

  // A held output stalls every stage, including the ROM read.
  assign w_adv    = !(r_s3_vld && !out_ready);
  assign in_ready = (r_state == RUN) && (r_in_cnt < r_len) && w_adv;
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_s3_vld && out_ready;

  assign rom_en   = w_in_hs;
  assign rom_addr = r_base + r_in_cnt;

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_s3_vld;
  assign out_idx   = r_s3_idx;

  assign w_c = rom_dout[2*TW-1:TW];
  assign w_s = rom_dout[TW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_in_hs)
        r_in_cnt <= r_in_cnt + AW'(1);
      // done lands in the cycle where DRAIN sees out_cnt == len.
      if (w_out_hs) begin
        r_out_cnt <= r_out_cnt + AW'(1);
        if (r_out_cnt == r_len - AW'(1))
          r_done <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_base    <= blk_long ? AW'(LONG_BASE) : AW'(SHORT_BASE);
            r_len     <= blk_long ? AW'(LONG_LEN) : AW'(SHORT_LEN);
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
          end
        end
        RUN: begin
          if (r_in_cnt == r_len)
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (r_out_cnt == r_len) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
      r_s1_idx <= '0;
      r_s2_idx <= '0;
      r_s3_idx <= '0;
      r_s1_re  <= '0;
      r_s1_im  <= '0;
    end else if (w_adv) begin
      r_s1_vld <= w_in_hs;
      r_s1_idx <= r_in_cnt[IDX_W-1:0];
      r_s1_re  <= in_re;
      r_s1_im  <= in_im;
      r_s2_vld <= r_s1_vld;
      r_s2_idx <= r_s1_idx;
      r_s3_vld <= r_s2_vld;
      r_s3_idx <= r_s2_idx;
    end
  end

  imdct_cmul_round #(
    .DW   (DW),
    .TW   (TW),
    .FRAC (FRAC)
  ) u_cmul (
    .clk   (clk),
    .rst_n (rst_n),
    .i_adv (w_adv),
    .i_re  (r_s1_re),
    .i_im  (r_s1_im),
    .i_c   (w_c),
    .i_s   (w_s),
    .o_re  (out_re),
    .o_im  (out_im)
  );

endmodule

// File: tb/tb_imdct_pretwiddle.sv
// tb_imdct_pretwiddle: directed bench with a registered twiddle ROM model and output capture queues.
// Expected samples are hand constants for the called-out entries and a 64-bit integer model elsewhere.
module tb_imdct_pretwiddle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        blk_long;
  logic        busy;
  logic        done;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_re;
  logic [31:0] in_im;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [63:0] rom_dout = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_re;
  logic [31:0] out_im;
  logic [8:0]  out_idx;

  int n_checks;
  int n_errors;
  int cyc = 0;
  int done_cnt;
  int first_in;
  int last_in;
  int first_out;

  logic [31:0] drv_re [512];
  logic [31:0] drv_im [512];
  logic [31:0] exp_re [512];
  logic [31:0] exp_im [512];
  logic [31:0] got_re [$];
  logic [31:0] got_im [$];
  logic [8:0]  got_idx [$];
  logic [9:0]  addr_q [$];

  always #5 clk = ~clk;

  imdct_pretwiddle #(
    .DW   (32),
    .TW   (32),
    .FRAC (30)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .blk_long  (blk_long),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx)
  );

  function automatic logic [63:0] rom_word(input int unsigned a);
    case (a)
      0:       return 64'hbf9bc731_ff9b783c;
      1:       return 64'h80000000_ffffffff;
      64:      return 64'hbff3703e_fff36f02;
      default: return {32'h20000000 + a * 32'h00012345, 32'hf0000000 + a * 32'h00031000};
    endcase
  endfunction

  function automatic logic [63:0] model(input int re, input int im, input logic [63:0] w);
    int     c;
    int     s;
    longint yr;
    longint yi;
    c  = w[63:32];
    s  = w[31:0];
    yr = longint'(re) * longint'(c) - longint'(im) * longint'(s);
    yi = longint'(re) * longint'(s) + longint'(im) * longint'(c);
    yr = (yr + 64'sd536870912) >>> 30;
    yi = (yi + 64'sd536870912) >>> 30;
    return {yr[31:0], yi[31:0]};
  endfunction

  always @(posedge clk) begin
    if (rom_en) rom_dout <= rom_word(32'(rom_addr));
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (out_valid && out_ready) begin
      got_re.push_back(out_re);
      got_im.push_back(out_im);
      got_idx.push_back(out_idx);
    end
    if (out_valid && first_out < 0) first_out = cyc;
    if (rom_en) begin
      addr_q.push_back(rom_addr);
      if (first_in < 0) first_in = cyc;
      last_in = cyc;
    end
    if (done) done_cnt++;
  end

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int base);
    for (int k = 0; k < 512; k++) begin
      logic [63:0] m;
      drv_re[k] = 32'(k * 40503) - 32'h00800000;
      drv_im[k] = 32'h00400000 - 32'(k * 7919);
      m = model(drv_re[k], drv_im[k], rom_word(base + k));
      exp_re[k] = m[63:32];
      exp_im[k] = m[31:0];
    end
  endtask

  task automatic clear_capture();
    got_re.delete();
    got_im.delete();
    got_idx.delete();
    addr_q.delete();
    done_cnt  = 0;
    first_in  = -1;
    last_in   = -1;
    first_out = -1;
  endtask

  task automatic feed(input logic lng, input int n, input int restart_at, input int stall_at,
                      input logic bubbles);
    int          k;
    int          guard;
    logic        hs;
    logic        bub;
    logic [95:0] held;
    k = 0; guard = 0; bub = 1'b0;
    @(negedge clk);
    start = 1'b1; blk_long = lng;
    @(negedge clk);
    start = 1'b0; blk_long = 1'b0;
    #1 check_val("busy_set", 96'(busy), 96'(1));
    while (k < n && guard < 5000) begin
      guard++;
      if (k == stall_at && out_valid) begin
        stall_at  = -1;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_re = drv_re[k]; in_im = drv_im[k];
        #1 held = {out_re, out_im, 23'd0, out_idx};
        for (int c = 0; c < 5; c++) begin
          if (c > 0) check_val("bp_hold", {out_re, out_im, 23'd0, out_idx}, held);
          check_val("bp_in_ready", 96'(in_ready), 96'(0));
          check_val("bp_rom_en", 96'(rom_en), 96'(0));
          check_val("bp_valid", 96'(out_valid), 96'(1));
          @(negedge clk); #1;
        end
        out_ready = 1'b1;
      end
      if (bubbles && (k % 7 == 3) && !bub) begin
        in_valid = 1'b0; bub = 1'b1;
      end else begin
        in_valid = 1'b1; in_re = drv_re[k]; in_im = drv_im[k];
      end
      if (k == restart_at) begin
        start = 1'b1; blk_long = !lng; restart_at = -1;
      end
      #1 hs = in_valid && in_ready;
      @(posedge clk);
      if (hs) begin k++; bub = 1'b0; end
      @(negedge clk);
      start = 1'b0; blk_long = 1'b0;
    end
    in_valid = 1'b0;
    check_val("feed_bound", 96'(k), 96'(n));
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (done_cnt == 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check_val("done_seen", 96'(done_cnt > 0), 96'(1));
    repeat (4) @(negedge clk);
  endtask

  task automatic verify(input string nm, input int base, input int n);
    check_val({nm, "_n_out"}, 96'(got_re.size()), 96'(n));
    check_val({nm, "_n_addr"}, 96'(addr_q.size()), 96'(n));
    check_val({nm, "_done_cnt"}, 96'(done_cnt), 96'(1));
    check_val({nm, "_busy_clr"}, 96'(busy), 96'(0));
    for (int k = 0; k < n && k < got_re.size(); k++) begin
      check_val($sformatf("%s_re[%0d]", nm, k), 96'(got_re[k]), 96'(exp_re[k]));
      check_val($sformatf("%s_im[%0d]", nm, k), 96'(got_im[k]), 96'(exp_im[k]));
      check_val($sformatf("%s_idx[%0d]", nm, k), 96'(got_idx[k]), 96'(k));
    end
    for (int k = 0; k < n && k < addr_q.size(); k++)
      check_val($sformatf("%s_addr[%0d]", nm, k), 96'(addr_q[k]), 96'(base + k));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; blk_long = 1'b0;
    in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
    clear_capture();

    repeat (3) @(negedge clk);
    #1;
    check_val("rst_busy", 96'(busy), 96'(0));
    check_val("rst_done", 96'(done), 96'(0));
    check_val("rst_in_ready", 96'(in_ready), 96'(0));
    check_val("rst_rom", {85'd0, rom_en, rom_addr}, 96'(0));
    check_val("rst_out", {out_re, out_im, 22'd0, out_valid, out_idx}, 96'(0));
    rst_n = 1'b1;

    // Short transform: unit real input at k=0, overflow-prone input at k=1.
    fill(0);
    drv_re[0] = 32'h40000000; drv_im[0] = 32'h00000000;
    exp_re[0] = 32'hbf9bc731; exp_im[0] = 32'hff9b783c;
    drv_re[1] = 32'h7fffffff; drv_im[1] = 32'h7fffffff;
`ifdef IMDCT_PRETW_SAT_EN
    exp_re[1] = 32'h80000000; exp_im[1] = 32'h80000000;
`else
    exp_re[1] = 32'h00000004; exp_im[1] = 32'h00000000;
`endif
    clear_capture();
    feed(1'b0, 64, -1, -1, 1'b1);
    wait_done();
    verify("short", 0, 64);
    check_val("short_latency", 96'(first_out - first_in), 96'(3));

    // Long transform, continuous input.
    fill(64);
    drv_re[0] = 32'h40000000; drv_im[0] = 32'h00000000;
    exp_re[0] = 32'hbff3703e; exp_im[0] = 32'hfff36f02;
    clear_capture();
    feed(1'b1, 512, -1, -1, 1'b0);
    wait_done();
    verify("long", 64, 512);
    if (addr_q.size() == 512)
      check_val("long_last_addr", 96'(addr_q[511]), 96'(575));
    check_val("long_thru", 96'(last_in - first_in), 96'(511));

    // Imaginary unit at k=0, stray start mid-run, 5-cycle output stall.
    fill(0);
    drv_re[0] = 32'h00000000; drv_im[0] = 32'h40000000;
    exp_re[0] = 32'h006487c4; exp_im[0] = 32'hbf9bc731;
    clear_capture();
    feed(1'b0, 64, 20, 30, 1'b1);
    wait_done();
    verify("imag_bp", 0, 64);

    // Abort a long transform with results still in flight.
    fill(64);
    clear_capture();
    feed(1'b1, 20, -1, -1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check_val("abort_busy", 96'(busy), 96'(0));
    check_val("abort_hs", {93'd0, in_ready, rom_en, done}, 96'(0));
    check_val("abort_out", {out_re, out_im, 22'd0, out_valid, out_idx}, 96'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_val("abort_no_done", 96'(done_cnt), 96'(0));

    // Fresh short transform after the abort.
    fill(0);
    clear_capture();
    feed(1'b0, 64, -1, -1, 1'b0);
    wait_done();
    verify("post_rst", 0, 64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
